// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the I/D line-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-memory port between I-cache and D-cache.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  grant_cnt_i,
    output logic [CNT_W-1:0]  grant_cnt_d,
    output logic              proto_err
);

    state_t state, state_nx;
    gnt_t   gnt, last_grant, pick;
    logic   req_i, req_d, grant_go;

    assign req_i    = i_mem_read;
    assign req_d    = d_mem_read | d_mem_write;
    assign grant_go = (state == ST_IDLE) && (req_i || req_d);

    // On a tie, whoever was not served last wins.
    always_comb begin
        pick = GNT_I;
        if (req_i && req_d) begin
            pick = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (req_d) begin
            pick = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (req_i || req_d) state_nx = ST_BUSY;
            ST_BUSY:    if (mem_ready) state_nx = ST_RELEASE;
            ST_RELEASE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            gnt        <= GNT_I;
            last_grant <= GNT_D;
            proto_err  <= 1'b0;
        end else begin
            if (i_mem_write) begin
                proto_err <= 1'b1;
            end
            if (grant_go) begin
                gnt        <= pick;
                last_grant <= pick;
                if (pick == GNT_I) begin
                    mem_addr  <= i_mem_addr;
                    mem_wdata <= '0;
                    mem_read  <= 1'b1;
                    mem_write <= 1'b0;
                end else begin
                    // A simultaneous read+write from the D-cache is served as the write.
                    mem_addr  <= d_mem_addr;
                    mem_wdata <= d_mem_wdata;
                    mem_write <= d_mem_write;
                    mem_read  <= d_mem_read & ~d_mem_write;
                    if (d_mem_read && d_mem_write) begin
                        proto_err <= 1'b1;
                    end
                end
            end else if ((state == ST_BUSY) && mem_ready) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

    always_comb begin
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        i_mem_rdata = '0;
        d_mem_rdata = '0;
        if (state == ST_BUSY) begin
            if (gnt == GNT_I) begin
                i_mem_ready = mem_ready;
                i_mem_rdata = mem_rdata;
            end else begin
                d_mem_ready = mem_ready;
                d_mem_rdata = mem_rdata;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_i (
        .clk   (clk),
        .clear (proc_reset),
        .inc   (grant_go && (pick == GNT_I)),
        .count (grant_cnt_i)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
        .clk   (clk),
        .clear (proc_reset),
        .inc   (grant_go && (pick == GNT_D)),
        .count (grant_cnt_d)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven check of mem_port_arbiter plus multi-cycle corner sequences.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
    localparam logic [127:0] RD = {16{8'hA5}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              proc_reset;
    logic              i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_ready;
    logic [ADDR_W-1:0] i_mem_addr, d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata, mem_rdata;
    logic [DATA_W-1:0] i_mem_rdata, d_mem_rdata, mem_wdata;
    logic              i_mem_ready, d_mem_ready, mem_read, mem_write, proto_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       grant_cnt_i, grant_cnt_d;

    logic [DATA_W-1:0] i_rdata2, d_rdata2, mem_wdata2;
    logic              i_ready2, d_ready2, mem_read2, mem_write2, proto_err2;
    logic [ADDR_W-1:0] mem_addr2;
    logic [1:0]        cnt_i2, cnt_d2;

    mem_port_arbiter u_dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_cnt_i(grant_cnt_i), .grant_cnt_d(grant_cnt_d), .proto_err(proto_err)
    );

    mem_port_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .proc_reset(proc_reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_rdata2), .i_mem_ready(i_ready2),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_rdata2), .d_mem_ready(d_ready2),
        .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_cnt_i(cnt_i2), .grant_cnt_d(cnt_d2), .proto_err(proto_err2)
    );

    typedef struct {
        logic        rst, ir, iw, dr, dw, mrdy;
        logic        emr, emw, eir, edr, eirv, edrv, eperr;
        logic [15:0] eci, ecd;
        logic [27:0] eaddr;
        logic [127:0] ewd;
    } vec_t;

    vec_t tbl[21];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, ir, iw, dr, dw, mrdy,
                                input logic emr, emw, eir, edr, eirv, edrv, eperr,
                                input logic [15:0] eci, ecd,
                                input logic [27:0] eaddr, input logic [127:0] ewd);
        vec_t v;
        v.rst = rst; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.mrdy = mrdy;
        v.emr = emr; v.emw = emw; v.eir = eir; v.edr = edr;
        v.eirv = eirv; v.edrv = edrv; v.eperr = eperr;
        v.eci = eci; v.ecd = ecd; v.eaddr = eaddr; v.ewd = ewd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete I-cache read; returns in IDLE after the RELEASE cycle.
    task automatic do_i_txn(input string nm);
        int w;
        w = 0;
        i_mem_read = 1'b1;
        while (!mem_read && w < 8) begin
            tick();
            w++;
        end
        check({nm, "_grant"}, mem_read, 1'b1);
        mem_ready = 1'b1;
        #1;
        check({nm, "_iready"}, i_mem_ready, 1'b1);
        tick();
        mem_ready  = 1'b0;
        i_mem_read = 1'b0;
        tick();
    endtask

    initial begin
        int w;
        proc_reset = 1'b1;
        i_mem_read = 1'b0; i_mem_write = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        mem_ready = 1'b0;
        i_mem_addr = 28'h0000010; d_mem_addr = 28'h0000020;
        d_mem_wdata = 128'h1234; mem_rdata = RD;
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;

        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_cnt_i", grant_cnt_i, '0);
        check("rst_cnt_d", grant_cnt_d, '0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_i_rdata", i_mem_rdata, '0);

        // Inputs are applied in a cycle; outputs are observed in that same cycle before its edge.
        tbl[0]  = mk(0,1,0,0,0,0, 0,0,0,0,0,0,0, 0,0,28'h00,128'h0);
        tbl[1]  = mk(0,1,0,0,0,0, 1,0,0,0,1,0,0, 1,0,28'h10,128'h0);
        tbl[2]  = mk(0,1,0,0,0,0, 1,0,0,0,1,0,0, 1,0,28'h10,128'h0);
        tbl[3]  = mk(0,1,0,0,0,0, 1,0,0,0,1,0,0, 1,0,28'h10,128'h0);
        tbl[4]  = mk(0,1,0,0,0,1, 1,0,1,0,1,0,0, 1,0,28'h10,128'h0);
        tbl[5]  = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,28'h10,128'h0);
        tbl[6]  = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,28'h10,128'h0);
        tbl[7]  = mk(1,0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,28'h10,128'h0);
        tbl[8]  = mk(0,1,0,0,1,0, 0,0,0,0,0,0,0, 0,0,28'h00,128'h0);
        tbl[9]  = mk(0,1,0,0,1,1, 1,0,1,0,1,0,0, 1,0,28'h10,128'h0);
        tbl[10] = mk(0,0,0,0,1,0, 0,0,0,0,0,0,0, 1,0,28'h10,128'h0);
        tbl[11] = mk(0,0,0,0,1,0, 0,0,0,0,0,0,0, 1,0,28'h10,128'h0);
        tbl[12] = mk(0,0,0,0,1,1, 0,1,0,1,0,1,0, 1,1,28'h20,128'h1234);
        tbl[13] = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0, 1,1,28'h20,128'h1234);
        tbl[14] = mk(0,0,0,1,1,0, 0,0,0,0,0,0,0, 1,1,28'h20,128'h1234);
        tbl[15] = mk(0,0,0,1,1,1, 0,1,0,1,0,1,1, 1,2,28'h20,128'h1234);
        tbl[16] = mk(0,0,0,0,0,0, 0,0,0,0,0,0,1, 1,2,28'h20,128'h1234);
        tbl[17] = mk(1,0,0,0,0,0, 0,0,0,0,0,0,1, 1,2,28'h20,128'h1234);
        tbl[18] = mk(0,0,1,0,0,0, 0,0,0,0,0,0,0, 0,0,28'h00,128'h0);
        tbl[19] = mk(0,0,0,0,0,0, 0,0,0,0,0,0,1, 0,0,28'h00,128'h0);
        tbl[20] = mk(0,0,0,0,0,0, 0,0,0,0,0,0,1, 0,0,28'h00,128'h0);

        for (int k = 0; k < 21; k++) begin
            proc_reset  = tbl[k].rst;
            i_mem_read  = tbl[k].ir;
            i_mem_write = tbl[k].iw;
            d_mem_read  = tbl[k].dr;
            d_mem_write = tbl[k].dw;
            mem_ready   = tbl[k].mrdy;
            #1;
            check($sformatf("v%0d_mem_read", k), mem_read, tbl[k].emr);
            check($sformatf("v%0d_mem_write", k), mem_write, tbl[k].emw);
            check($sformatf("v%0d_i_ready", k), i_mem_ready, tbl[k].eir);
            check($sformatf("v%0d_d_ready", k), d_mem_ready, tbl[k].edr);
            check($sformatf("v%0d_i_rdata", k), i_mem_rdata, tbl[k].eirv ? RD : 128'h0);
            check($sformatf("v%0d_d_rdata", k), d_mem_rdata, tbl[k].edrv ? RD : 128'h0);
            check($sformatf("v%0d_proto_err", k), proto_err, tbl[k].eperr);
            check($sformatf("v%0d_cnt_i", k), grant_cnt_i, tbl[k].eci);
            check($sformatf("v%0d_cnt_d", k), grant_cnt_d, tbl[k].ecd);
            check($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].eaddr);
            check($sformatf("v%0d_mem_wdata", k), mem_wdata, tbl[k].ewd);
            tick();
        end
        proc_reset = 1'b0; i_mem_write = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
        mem_ready = 1'b0; i_mem_read = 1'b0;

        // Both requesting continuously: grants alternate starting with I.
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
        i_mem_read = 1'b1;
        d_mem_read = 1'b1;
        for (int n = 0; n < 6; n++) begin
            w = 0;
            while (!mem_read && w < 8) begin
                tick();
                w++;
            end
            check($sformatf("rr%0d_grant", n), mem_read, 1'b1);
            check($sformatf("rr%0d_addr", n), mem_addr, (n % 2 == 0) ? 28'h10 : 28'h20);
            mem_ready = 1'b1;
            #1;
            check($sformatf("rr%0d_i_ready", n), i_mem_ready, (n % 2 == 0));
            check($sformatf("rr%0d_d_ready", n), d_mem_ready, (n % 2 == 1));
            tick();
            mem_ready = 1'b0;
        end
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        tick();
        check("rr_cnt_i", grant_cnt_i, 16'd3);
        check("rr_cnt_d", grant_cnt_d, 16'd3);

        // Reset while BUSY abandons the transaction; a late mem_ready is ignored.
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
        i_mem_read = 1'b1;
        tick();
        check("mid_rst_busy", mem_read, 1'b1);
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
        i_mem_read = 1'b0;
        check("mid_rst_mem_read", mem_read, 1'b0);
        check("mid_rst_mem_addr", mem_addr, '0);
        check("mid_rst_cnt_i", grant_cnt_i, '0);
        mem_ready = 1'b1;
        #1;
        check("mid_rst_i_ready", i_mem_ready, 1'b0);
        check("mid_rst_d_ready", d_mem_ready, 1'b0);
        check("mid_rst_i_rdata", i_mem_rdata, '0);
        tick();
        mem_ready = 1'b0;
        check("mid_rst_no_req", mem_read, 1'b0);
        d_mem_read = 1'b1;
        tick();
        check("post_rst_grant", mem_read, 1'b1);
        check("post_rst_addr", mem_addr, 28'h20);
        check("post_rst_cnt_d", grant_cnt_d, 16'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        d_mem_read = 1'b0;
        tick();

        // Two-bit counter instance saturates at 3.
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            do_i_txn($sformatf("sat%0d", k));
            check($sformatf("sat%0d_cnt2", k), cnt_i2, (k > 3) ? 2'd3 : 2'(k));
            check($sformatf("sat%0d_cnt16", k), grant_cnt_i, 16'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow 128-bit line memory port between the read-only instruction cache and the write-back data cache.
- Sits between both caches' mem_* interfaces and the single external memory.
- Grants whole-line transactions with round-robin fairness and holds each transaction until the memory signals ready.
- Keeps per-requester grant counters and a sticky protocol-error flag.

Parameters:
ADDR_W, 28, line address width (address bits [31:4])
DATA_W, 128, line width
CNT_W, 16, width of each grant counter (saturating)

Ports:
clk  in  1  clock
proc_reset  in  1  synchronous active-high reset
i_mem_read  in  1  I-cache line read request; held until i_mem_ready
i_mem_write  in  1  I-cache write; must stay 0 (protocol check only)
i_mem_addr  in  ADDR_W  I-cache line address
i_mem_rdata  out  DATA_W  line data to I-cache
i_mem_ready  out  1  one-cycle completion pulse to I-cache
d_mem_read  in  1  D-cache line read request
d_mem_write  in  1  D-cache line write-back request
d_mem_addr  in  ADDR_W  D-cache line address
d_mem_wdata  in  DATA_W  D-cache write-back line
d_mem_rdata  out  DATA_W  line data to D-cache
d_mem_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  to memory; registered
mem_write  out  1  to memory; registered
mem_addr  out  ADDR_W  to memory; registered
mem_wdata  out  DATA_W  to memory; registered
mem_rdata  in  DATA_W  from memory
mem_ready  in  1  memory completion
grant_cnt_i  out  CNT_W  number of I grants
grant_cnt_d  out  CNT_W  number of D grants
proto_err  out  1  sticky protocol violation

Behaviour:
- Reset (synchronous, active-high, takes effect at the next clk edge, including mid-transaction):
  - state=IDLE.
  - mem_read=mem_write=0; mem_addr=0; mem_wdata=0.
  - Counters=0; proto_err=0.
  - last_grant=D, so I wins the first tie.
  - Any memory transaction in flight is abandoned. A mem_ready that arrives after reset is ignored.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - req_i = i_mem_read. req_d = d_mem_read | d_mem_write.
  - Only one requesting -> grant it. Both requesting -> grant the one that is not last_grant.
  - On grant, at the edge:
    - Latch addr and wdata (wdata=0 for I).
    - mem_read <= read op; mem_write <= write op. If d_mem_write and d_mem_read are both high, the write wins and proto_err is set.
    - Update last_grant; increment the grantee's counter (saturates at all-ones); go BUSY.
  - Downstream request is visible 1 cycle after the requester asserts.
- BUSY:
  - Downstream outputs are held constant.
  - When mem_ready=1: the granted requester's *_mem_ready=1 combinationally in the same cycle, and its *_mem_rdata=mem_rdata.
  - At that edge: mem_read/mem_write <= 0; go RELEASE.
  - Requester inputs are not re-sampled while BUSY.
- RELEASE: one cycle with no grant, so the requester can drop its held request. Then go IDLE.
- Minimum transaction turnaround: grant edge + memory latency + 1 RELEASE cycle.
- Non-granted *_mem_ready is always 0. *_mem_rdata is 0 unless that requester is granted and in BUSY.
- mem_ready seen in IDLE or RELEASE is ignored. It does not set proto_err.
- i_mem_write=1 in any cycle sets proto_err and is otherwise ignored.
- proto_err is cleared only by reset.
- A requester that drops its request while BUSY is a protocol violation: it is not detected, and the transaction completes normally.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding constants ST_IDLE, ST_BUSY, ST_RELEASE.
  - Grant IDs GNT_I=0, GNT_D=1.
  - Default widths.
- One natural sub-module: sat_counter (CNT_W, inc, clear), instantiated twice for the grant counters.
- FSM and muxing stay in the top.

Test Plan:
1. I only: i_mem_read=1, i_mem_addr=28'h0000010, memory ready after 4 cycles with rdata=128'hA5... -> mem_read=1 from the cycle after the request; i_mem_ready pulses once with i_mem_rdata=128'hA5...; grant_cnt_i=1.
2. Simultaneous I read and D write (addr 28'h0000020, wdata=128'h1234) after reset -> I granted first (mem_write=0). After RELEASE, D is granted with mem_write=1 and mem_wdata=128'h1234. Counters end at 1/1.
3. Both requesting continuously for 6 transactions -> grants alternate I,D,I,D,I,D; each counter=3.
4. proc_reset asserted while BUSY, then mem_ready arrives -> outputs zero at the reset edge; no *_mem_ready pulse; state IDLE.
5. d_mem_read=d_mem_write=1 -> mem_write=1, mem_read=0, proto_err=1 and remains set until reset. Separately, i_mem_write=1 sets proto_err.
6. CNT_W=2 with 5 I grants -> grant_cnt_i saturates at 3.
